// File: rtl/ycbcr_to_rgb_seq.sv
// ---------------------------------------------------------------------------
// ycbcr_to_rgb_seq
//   Inverse colour transform: level-shifted Q8.16 Y/Cb/Cr back to 8-bit RGB.
//   A single serial shift-add multiplier is shared by the four products
//   (Cr*K_RCR, Cb*K_GCB, Cr*K_GCR, Cb*K_BCB), consuming one coefficient bit
//   per cycle, LSB first. Only one pixel is in flight at a time.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active high
//   in_valid   in   y_in/cb_in/cr_in valid
//   in_ready   out  block idle; a pixel is accepted on in_valid && in_ready
//   y_in       in   signed Q8.16, Y-128
//   cb_in      in   signed Q8.16, Cb-128
//   cr_in      in   signed Q8.16, Cr-128
//   out_valid  out  r/g/b_out valid, held until out_ready
//   out_ready  in   downstream accepts on out_valid && out_ready
//   r_out      out  red,   0..255
//   g_out      out  green, 0..255
//   b_out      out  blue,  0..255
// ---------------------------------------------------------------------------
module ycbcr_to_rgb_seq #(
  parameter int COEF_W = 18,
  parameter int FRAC   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] y_in,
  input  logic signed [31:0] cb_in,
  input  logic signed [31:0] cr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         r_out,
  output logic [7:0]         g_out,
  output logic [7:0]         b_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam int PW = 32 + COEF_W;         // full signed product width
  localparam int AW = 40;                  // accumulator / sum width
  localparam int BW = $clog2(COEF_W);      // coefficient bit counter width

  localparam logic [COEF_W-1:0] K_RCR = COEF_W'(18'h166E9);
  localparam logic [COEF_W-1:0] K_GCB = COEF_W'(18'h0581A);
  localparam logic [COEF_W-1:0] K_GCR = COEF_W'(18'h0B6D2);
  localparam logic [COEF_W-1:0] K_BCB = COEF_W'(18'h1C5A2);

  localparam logic [BW-1:0]        LAST_BIT = BW'(COEF_W - 1);
  localparam logic [2:0]           IDX_END  = 3'd4;
  localparam logic signed [AW-1:0] Y_OFS    = AW'(128 * (2 ** FRAC));
  localparam logic signed [AW-1:0] RND      = AW'(2 ** (FRAC - 1));

  logic [1:0]               r_state;
  logic signed [31:0]       r_y, r_cb, r_cr;
  logic [2:0]               r_idx;       // product index, 4 = all bits done
  logic [BW-1:0]            r_bit;       // coefficient bit being consumed
  logic signed [PW-1:0]     r_mcand;     // operand, shifted left once per bit
  logic signed [PW-1:0]     r_prod;      // partial product of current term
  logic signed [AW-1:0]     r_done;      // finished product, waiting to fold
  logic                     r_done_vld;
  logic [1:0]               r_done_idx;
  logic signed [AW-1:0]     r_acc_r, r_acc_g, r_acc_b;

  logic [COEF_W-1:0]        w_coef;
  logic                     w_coef_bit;
  logic signed [PW-1:0]     w_prod_nxt;
  logic signed [AW-1:0]     w_prod_q;
  logic signed [AW-1:0]     w_y_ext;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_coef = K_RCR;
    case (r_idx)
      3'd1:    w_coef = K_GCB;
      3'd2:    w_coef = K_GCR;
      3'd3:    w_coef = K_BCB;
      default: w_coef = K_RCR;
    endcase
  end

  assign w_coef_bit = w_coef[r_bit];
  assign w_prod_nxt = r_prod + (w_coef_bit ? r_mcand : '0);
  // Floor of the Q2.16 scaling; the result always fits well inside 40 bits.
  assign w_prod_q   = AW'(w_prod_nxt >>> FRAC);
  assign w_y_ext    = Y_OFS + AW'(r_y);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);

  // Round half up, drop the fraction, clamp to 0..255.
  function automatic logic [7:0] sat8(input logic signed [AW-1:0] s);
    logic signed [AW-1:0] q;
    q = (s + RND) >>> FRAC;
    if (q[AW-1])            return 8'h00;
    else if (q > 40'sd255)  return 8'hFF;
    else                    return q[7:0];
  endfunction

  // A finished product is parked in r_done and folded into its channel on
  // the following edge, overlapping the first bit of the next product. This
  // keeps the multiplier adder and the accumulator adders in separate cycles;
  // the last fold costs one extra MUL cycle before FIN.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset clears the whole datapath, not just the FSM, so an
      // interrupted pixel leaves nothing behind in the accumulators.
      r_state    <= S_IDLE;
      r_y        <= '0;
      r_cb       <= '0;
      r_cr       <= '0;
      r_idx      <= '0;
      r_bit      <= '0;
      r_mcand    <= '0;
      r_prod     <= '0;
      r_done     <= '0;
      r_done_vld <= 1'b0;
      r_done_idx <= '0;
      r_acc_r    <= '0;
      r_acc_g    <= '0;
      r_acc_b    <= '0;
      r_out      <= '0;
      g_out      <= '0;
      b_out      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done_vld <= 1'b0;
          if (in_valid) begin
            r_y     <= y_in;
            r_cb    <= cb_in;
            r_cr    <= cr_in;
            r_idx   <= '0;
            r_bit   <= '0;
            r_prod  <= '0;
            r_mcand <= PW'(cr_in);         // first product is Cr*K_RCR
            r_acc_r <= '0;
            r_acc_g <= '0;
            r_acc_b <= '0;
            r_state <= S_MUL;
          end
        end

        S_MUL: begin
          r_done_vld <= 1'b0;
          if (r_done_vld) begin
            case (r_done_idx)
              2'd0:    r_acc_r <= r_acc_r + r_done;
              2'd3:    r_acc_b <= r_acc_b + r_done;
              default: r_acc_g <= r_acc_g - r_done;  // both G terms subtract
            endcase
          end
          if (r_idx != IDX_END) begin
            r_prod  <= w_prod_nxt;
            r_mcand <= r_mcand <<< 1;
            r_bit   <= r_bit + BW'(1);
            if (r_bit == LAST_BIT) begin
              r_done     <= w_prod_q;
              r_done_vld <= 1'b1;
              r_done_idx <= r_idx[1:0];
              r_prod     <= '0;
              r_bit      <= '0;
              // Odd-numbered products use Cb, even-numbered ones Cr.
              r_mcand    <= PW'(r_idx[0] ? r_cr : r_cb);
              r_idx      <= r_idx + 3'd1;
            end
          end else begin
            r_state <= S_FIN;                // last fold happens this edge
          end
        end

        S_FIN: begin
          r_out   <= sat8(w_y_ext + r_acc_r);
          g_out   <= sat8(w_y_ext + r_acc_g);
          b_out   <= sat8(w_y_ext + r_acc_b);
          r_state <= S_OUT;
        end

        default: begin                       // S_OUT
          if (out_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ycbcr_to_rgb_seq.sv
// ---------------------------------------------------------------------------
// tb_ycbcr_to_rgb_seq
//   Self-checking bench for ycbcr_to_rgb_seq: a table of directed vectors
//   with hand-computed RGB, round-trip vectors from a real-valued forward
//   converter, a full gray sweep, and hand-written backpressure and
//   mid-computation reset sequences.
// ---------------------------------------------------------------------------
module tb_ycbcr_to_rgb_seq;

  localparam int LAT     = 74;
  localparam int MAX_LAT = 200;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] y_in, cb_in, cr_in;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         r_out, g_out, b_out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic signed [31:0] y;
    logic signed [31:0] cb;
    logic signed [31:0] cr;
    int                 r;
    int                 g;
    int                 b;
    int                 tol;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  ycbcr_to_rgb_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .cb_in     (cb_in),
    .cr_in     (cr_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out)
  );

  task automatic check(input string name, input longint act, input longint exp,
                       input int tol = 0);
    n_checks++;
    if (act > exp + tol || act < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic signed [31:0] q16(input real v);
    return 32'($rtoi($floor(v * 65536.0 + 0.5)));
  endfunction

  // Real-valued forward converter producing the level-shifted inputs.
  function automatic vec_t fwd(input int r, input int g, input int b);
    vec_t v;
    real yy, cb, cr;
    yy = 0.299 * r + 0.587 * g + 0.114 * b;
    cb = -0.168736 * r - 0.331264 * g + 0.5 * b;
    cr = 0.5 * r - 0.418688 * g - 0.081312 * b;
    v.y   = q16(yy - 128.0);
    v.cb  = q16(cb);
    v.cr  = q16(cr);
    v.r   = r;
    v.g   = g;
    v.b   = b;
    v.tol = 1;
    return v;
  endfunction

  // Presents one pixel, waits (bounded) for the result, then completes the
  // output handshake. lat = edges from accept to out_valid, MAX_LAT on timeout.
  task automatic run_pixel(input logic signed [31:0] y, input logic signed [31:0] cb,
                           input logic signed [31:0] cr, input bit early_ready,
                           output logic [7:0] r, output logic [7:0] g,
                           output logic [7:0] b, output int lat);
    @(negedge clk);
    y_in      = y;
    cb_in     = cb;
    cr_in     = cr;
    in_valid  = 1'b1;
    out_ready = early_ready;
    check("in_ready_idle", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    y_in     = 32'h1234_5678;   // inputs must have been sampled at accept
    cb_in    = 32'h8765_4321;
    cr_in    = 32'h0F0F_0F0F;
    lat = 0;
    while (!out_valid && lat < MAX_LAT) begin
      @(posedge clk);
      #1 lat++;
    end
    r = r_out;
    g = g_out;
    b = b_out;
    if (lat >= MAX_LAT) begin
      apply_reset();
    end else begin
      if (!early_ready) begin
        @(negedge clk);
        out_ready = 1'b1;
      end
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] r, g, b;
    int lat;
    int k;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    y_in      = '0;
    cb_in     = '0;
    cr_in     = '0;

    // Hand-computed directed vectors.
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 128, 128, 128, 0});
    vecs.push_back('{32'h007F_0000, 32'h0000_0000, 32'h0000_0000, 255, 255, 255, 0});
    vecs.push_back('{32'hFF80_0000, 32'h0000_0000, 32'h0000_0000,   0,   0,   0, 0});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'h007F_0000, 255,  37, 128, 0});
    vecs.push_back('{32'h0000_0000, 32'h007F_0000, 32'h0000_0000, 128,  84, 255, 0});
    vecs.push_back('{32'h0000_0000, 32'hFF80_0000, 32'h0000_0000, 128, 172,   0, 0});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'h0000_8000, 129, 128, 128, 0});
    // Round-trip vectors: primaries, secondaries, an arbitrary colour.
    vecs.push_back(fwd(255,   0,   0));
    vecs.push_back(fwd(  0, 255,   0));
    vecs.push_back(fwd(  0,   0, 255));
    vecs.push_back(fwd(255, 255,   0));
    vecs.push_back(fwd(  0, 255, 255));
    vecs.push_back(fwd(255,   0, 255));
    vecs.push_back(fwd(200, 100,  50));

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready",  longint'(in_ready),  1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_r", longint'(r_out), 0);
    check("rst_g", longint'(g_out), 0);
    check("rst_b", longint'(b_out), 0);

    // Table-driven vectors; every other one with out_ready raised early.
    foreach (vecs[i]) begin
      run_pixel(vecs[i].y, vecs[i].cb, vecs[i].cr, bit'(i % 2), r, g, b, lat);
      check($sformatf("vec%0d_lat", i), lat, LAT);
      check($sformatf("vec%0d_r", i), longint'(r), vecs[i].r, vecs[i].tol);
      check($sformatf("vec%0d_g", i), longint'(g), vecs[i].g, vecs[i].tol);
      check($sformatf("vec%0d_b", i), longint'(b), vecs[i].b, vecs[i].tol);
    end

    // Gray sweep must reconstruct exactly.
    for (int gv = 0; gv < 256; gv++) begin
      run_pixel(32'((gv - 128) * 65536), '0, '0, 1'b1, r, g, b, lat);
      check($sformatf("gray%0d_r", gv), longint'(r), gv);
      check($sformatf("gray%0d_g", gv), longint'(g), gv);
      check($sformatf("gray%0d_b", gv), longint'(b), gv);
    end

    // Backpressure: OUT holds for 10 cycles while in_valid pulses are ignored.
    @(negedge clk);
    y_in      = '0;
    cb_in     = 32'h007F_0000;
    cr_in     = '0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < MAX_LAT) begin
      @(posedge clk);
      #1 lat++;
    end
    check("bp_lat", lat, LAT);
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = k[0];
      y_in     = 32'h007F_0000;
      cb_in    = 32'hFF80_0000;
      cr_in    = 32'hFF80_0000;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_out_valid", k), longint'(out_valid), 1);
      check($sformatf("bp%0d_in_ready", k),  longint'(in_ready),  0);
      check($sformatf("bp%0d_r", k), longint'(r_out), 128);
      check($sformatf("bp%0d_g", k), longint'(g_out), 84);
      check($sformatf("bp%0d_b", k), longint'(b_out), 255);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_release_in_ready",  longint'(in_ready),  1);
    check("bp_release_out_valid", longint'(out_valid), 0);
    run_pixel('0, '0, '0, 1'b0, r, g, b, lat);
    check("bp_next_lat", lat, LAT);
    check("bp_next_r", longint'(r), 128);
    check("bp_next_g", longint'(g), 128);
    check("bp_next_b", longint'(b), 128);

    // Reset 30 cycles into MUL, with non-zero outputs left from before.
    run_pixel('0, '0, 32'h007F_0000, 1'b0, r, g, b, lat);
    check("pre_rst_g", longint'(g), 37);
    @(negedge clk);
    y_in     = 32'h007F_0000;
    cb_in    = '0;
    cr_in    = '0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_in_ready",  longint'(in_ready),  1);
    check("mid_rst_r", longint'(r_out), 0);
    check("mid_rst_g", longint'(g_out), 0);
    check("mid_rst_b", longint'(b_out), 0);
    run_pixel('0, '0, '0, 1'b0, r, g, b, lat);
    check("post_rst_lat", lat, LAT);
    check("post_rst_r", longint'(r), 128);
    check("post_rst_g", longint'(g), 128);
    check("post_rst_b", longint'(b), 128);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
